param_cache_wbuf: RTL and testbench
===================================

# param_cache_wbuf

Parametrised 2-way set-associative write-back data cache with a one-entry victim write buffer. It sits between the processor's load/store port and the 128-bit block memory. A dirty-victim miss starts its refill immediately; the evicted block drains to memory later, in idle memory cycles. Set count and address width are parameters, and cache hits are served while the write buffer drains.

## Interface
- SET_BITS, default 2: log2 of the number of sets (default 4 sets).
- ADDR_W, default 30: processor word-address width. TAG_W = ADDR_W-2-SET_BITS; must be ≥1.

- clk  in  1  rising-edge clock.
- proc_reset  in  1  reset, synchronous, active-high.
- proc_read  in  1  load request; held with proc_addr stable while proc_stall=1.
- proc_write  in  1  store request; same hold rule. Never asserted together with proc_read.
- proc_addr  in  ADDR_W  word address = {tag, set, word offset[1:0]}.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data, combinational from the hit way.
- proc_stall  out  1  high while the request is not a hit.
- mem_read  out  1  block read request.
- mem_write  out  1  block write request.
- mem_addr  out  ADDR_W-2  block address.
- mem_wdata  out  128  block write data (write-buffer contents).
- mem_rdata  in  128  block read data, valid when mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse for the current read or write.

## Operation
- Per set and per way: data[127:0], tag, valid, dirty. Per set: recent bit = way last hit; victim = ~recent.
- Word w of a block occupies bits [32w+31:32w].
- Hit: (proc_read|proc_write) and some way has valid=1 with a matching tag. Hit way = 1 if way1 matches, else 0. Invalid ways never hit.
- Write buffer: wb_valid, wb_addr[ADDR_W-3:0], wb_data[127:0].
- FSM states: IDLE, DRAIN, REFILL.
- IDLE, on a miss:
  - If the victim is dirty and wb_valid=1, go to DRAIN.
  - If wb_valid=1 and wb_addr equals the missed block address, go to DRAIN. This is the hazard rule: never refill a block still pending in the buffer.
  - Otherwise go to REFILL. If the victim is dirty, load the victim's {tag,set} and data into the buffer and set wb_valid on this transition.
- IDLE, no miss and wb_valid=1: go to DRAIN (background drain).
- DRAIN: on mem_ready, clear wb_valid and go to IDLE. Hits are served during DRAIN: data write, dirty set, recent update all apply. A miss waits.
- REFILL: on mem_ready, go to IDLE and install into the victim way: data=mem_rdata, tag=proc tag, valid=1, dirty=0. The held request then hits the following cycle.
- Hit side effects (IDLE or DRAIN):
  - recent := hit way.
  - A store writes proc_wdata into the addressed word and sets dirty.
- proc_stall = (proc_read|proc_write) & ~hit. It is combinational, in every state.
- Memory outputs:
  - mem_read = (state==REFILL) & ~mem_ready.
  - mem_write = (state==DRAIN) & ~mem_ready.
  - mem_read and mem_write are never both high.
  - mem_addr = {proc tag, set} in REFILL, wb_addr otherwise.
  - mem_wdata = wb_data.

## Timing
- Reset (synchronous, one cycle):
  - state=IDLE; all valid, dirty, recent, tags, data and wb_* cleared.
  - Next cycle: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
- Reset during REFILL or DRAIN:
  - Abandons the transaction; the buffered block is lost.
  - Memory requests drop the following cycle.
  - A mem_ready arriving in the reset cycle is ignored.
- Hit latency: 0 cycles. Data is valid in the same cycle; a store commits at the next edge.
- Clean miss, or dirty miss with an empty buffer: 1 IDLE cycle, then REFILL for L cycles (L = memory latency, mem_ready on the last). The hit follows in the next cycle.
- Dirty miss with a full buffer: the DRAIN time is added first, then the path above.
- A miss arriving while a background DRAIN is in progress waits for that drain to complete.
- mem_ready outside DRAIN/REFILL is ignored.

## Test plan
- Reset then load of 0x0000_0010: stall=1, mem_read=1 with mem_addr=0x000_0004. mem_ready returns 128'h4444…_3333…_2222…_1111… after 3 cycles. The next cycle has stall=0 and proc_rdata=0x1111_1111.
- Store 0xDEAD_BEEF to 0x0000_0012 after it is resident: stall=0 in the same cycle, no mem traffic. A later load of the same address returns 0xDEAD_BEEF.
- Evict a dirty block:
  - Fill both ways of set 0 (blocks 0x0, 0x4), dirty way with block 0x0, then touch 0x4.
  - Miss on block 0x8: mem_read starts at 0x8 with no preceding write; wb holds block 0x0.
  - After refill with no request, mem_write occurs at 0x0 with the stored data.
- Second dirty eviction while the buffer is full: DRAIN at the buffered address completes before mem_read starts. Data for both evicted blocks arrives intact.
- Hazard: with block 0x0 in the buffer, load block 0x0 again. The drain completes first, then the refill re-reads the stored value.
- Hit during background DRAIN with mem_ready delayed 5 cycles: load hits with stall=0, and the store sets dirty. mem_write stays high until mem_ready.

Source files
------------

// File: rtl/param_cache_wbuf.sv
// 2-way set-associative write-back data cache with a one-entry victim write buffer.
// Dirty victims park in the buffer so the refill starts at once; the buffer drains in idle memory cycles.
module param_cache_wbuf #(
    parameter int SET_BITS = 2,
    parameter int ADDR_W   = 30
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - 2 - SET_BITS;
    localparam int BLK_W = ADDR_W - 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_REFILL = 2'd2;

    logic [127:0]     r_data   [2][SETS];
    logic [TAG_W-1:0] r_tag    [2][SETS];
    logic             r_valid  [2][SETS];
    logic             r_dirty  [2][SETS];
    logic             r_recent [SETS];

    logic [1:0]       r_state;
    logic             r_wb_valid;
    logic [BLK_W-1:0] r_wb_addr;
    logic [127:0]     r_wb_data;

    logic [SET_BITS-1:0] w_set;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_off;
    logic [BLK_W-1:0]    w_blk;
    logic                w_req;
    logic [1:0]          w_way_hit;
    logic                w_hit;
    logic                w_miss;
    logic                w_hit_way;
    logic                w_victim;
    logic                w_vdirty;
    logic                w_serve;
    logic                w_refill_done;
    logic                w_drain_done;
    logic                w_wb_load;
    logic [1:0]          w_state_next;
    logic [127:0]        w_line;
    logic [127:0]        w_merged;

    assign w_set = proc_addr[SET_BITS+1:2];
    assign w_tag = proc_addr[ADDR_W-1:SET_BITS+2];
    assign w_off = proc_addr[1:0];
    assign w_blk = proc_addr[ADDR_W-1:2];
    assign w_req = proc_read | proc_write;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign w_way_hit[gi] = r_valid[gi][w_set] && (r_tag[gi][w_set] == w_tag);
        end
    endgenerate

    assign w_hit     = w_req & (|w_way_hit);
    assign w_miss    = w_req & ~(|w_way_hit);
    assign w_hit_way = w_way_hit[1];
    assign w_line    = r_data[w_hit_way][w_set];
    assign w_victim  = ~r_recent[w_set];
    assign w_vdirty  = r_dirty[w_victim][w_set];

    assign w_serve       = w_hit & ((r_state == S_IDLE) | (r_state == S_DRAIN));
    assign w_refill_done = (r_state == S_REFILL) & mem_ready;
    assign w_drain_done  = (r_state == S_DRAIN) & mem_ready;

    assign proc_rdata = w_line[{w_off, 5'd0} +: 32];
    assign proc_stall = w_miss;
    assign mem_read   = (r_state == S_REFILL) & ~mem_ready;
    assign mem_write  = (r_state == S_DRAIN) & ~mem_ready;
    assign mem_addr   = (r_state == S_REFILL) ? w_blk : r_wb_addr;
    assign mem_wdata  = r_wb_data;

    always_comb begin
        w_merged = w_line;
        w_merged[{w_off, 5'd0} +: 32] = proc_wdata;
    end

    // A pending buffered block must reach memory before it may be refilled or displaced.
    always_comb begin
        w_state_next = r_state;
        w_wb_load    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    if (r_wb_valid && (w_vdirty || (r_wb_addr == w_blk))) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_state_next = S_REFILL;
                        w_wb_load    = w_vdirty;
                    end
                end else if (r_wb_valid) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN:  if (mem_ready) w_state_next = S_IDLE;
            S_REFILL: if (mem_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state    <= S_IDLE;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_wb_load) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= {r_tag[w_victim][w_set], w_set};
                r_wb_data  <= r_data[w_victim][w_set];
            end else if (w_drain_done) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 2; w++) begin
                    r_data[w][s]  <= '0;
                    r_tag[w][s]   <= '0;
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                end
                r_recent[s] <= 1'b0;
            end
        end else begin
            if (w_serve) begin
                r_recent[w_set] <= w_hit_way;
                if (proc_write) begin
                    r_data[w_hit_way][w_set]  <= w_merged;
                    r_dirty[w_hit_way][w_set] <= 1'b1;
                end
            end
            if (w_refill_done) begin
                r_data[w_victim][w_set]  <= mem_rdata;
                r_tag[w_victim][w_set]   <= w_tag;
                r_valid[w_victim][w_set] <= 1'b1;
                r_dirty[w_victim][w_set] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_param_cache_wbuf.sv
// Bench for param_cache_wbuf: behavioural cache/buffer model with per-cycle compare, a latency-programmable
// block memory, and directed scenarios with hand-computed expectations.
module tb_param_cache_wbuf;
    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    always #5 clk = ~clk;

    param_cache_wbuf #(.SET_BITS(2), .ADDR_W(30)) dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Block memory: untouched blocks read a pattern of {block[15:0], word index}.
    bit [127:0] bmem [bit [27:0]];
    int lat  = 3;
    int mcnt = 0;

    function automatic logic [127:0] bm_get(input logic [27:0] b);
        logic [127:0] v;
        if (bmem.exists(b)) return bmem[b];
        if (b == 28'h4) return {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int w = 0; w < 4; w++) v[32*w +: 32] = {b[15:0], 16'(w)};
        return v;
    endfunction

    always @(posedge clk) begin
        logic rd_now, wr_now;
        #1;
        rd_now = mem_read;
        wr_now = mem_write;
        if (mem_ready) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else if (rd_now || wr_now) begin
            mcnt++;
            if (mcnt >= lat) begin
                mcnt = 0;
                if (wr_now) bmem[mem_addr] = mem_wdata;
                else mem_rdata = bm_get(mem_addr);
                mem_ready = 1'b1;
            end
        end else begin
            mcnt = 0;
        end
    end

    // Model: lines per set/way, recent way, buffer, and phase 0=idle 1=draining 2=refilling.
    typedef struct { bit v; bit d; bit [25:0] tag; bit [127:0] data; } line_t;
    line_t      mc [4][2];
    bit         mrec [4];
    bit         mwbv;
    bit [27:0]  mwba;
    bit [127:0] mwbd;
    int         mst;

    function automatic int lookup(input logic [29:0] a);
        int hw = -1;
        for (int w = 0; w < 2; w++)
            if (mc[a[3:2]][w].v && mc[a[3:2]][w].tag == a[29:4]) hw = w;
        return hw;
    endfunction

    task automatic model_step();
        int s, o, hw, vic;
        bit req;
        s   = int'(proc_addr[3:2]);
        o   = int'(proc_addr[1:0]);
        req = proc_read | proc_write;
        hw  = req ? lookup(proc_addr) : -1;
        vic = mrec[s] ? 0 : 1;
        if (proc_reset) begin
            for (int i = 0; i < 4; i++) begin
                mrec[i] = 0;
                for (int w = 0; w < 2; w++) mc[i][w] = '{0, 0, 26'd0, 128'd0};
            end
            mwbv = 0; mwba = '0; mwbd = '0; mst = 0;
            return;
        end
        if (mst != 2 && hw >= 0) begin
            mrec[s] = hw[0];
            if (proc_write) begin
                mc[s][hw].data[32*o +: 32] = proc_wdata;
                mc[s][hw].d = 1;
            end
        end
        if (mst == 0) begin
            if (req && hw < 0) begin
                if (mwbv && (mc[s][vic].d || mwba == proc_addr[29:2])) mst = 1;
                else begin
                    if (mc[s][vic].d) begin
                        mwbv = 1;
                        mwba = {mc[s][vic].tag, proc_addr[3:2]};
                        mwbd = mc[s][vic].data;
                    end
                    mst = 2;
                end
            end else if (mwbv) mst = 1;
        end else if (mst == 1) begin
            if (mem_ready) begin mwbv = 0; mst = 0; end
        end else if (mem_ready) begin
            mc[s][vic] = '{1, 0, proc_addr[29:4], mem_rdata};
            mst = 0;
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        int hw;
        bit req, em_rd, em_wr;
        if (armed && !proc_reset) begin
            req = proc_read | proc_write;
            hw  = req ? lookup(proc_addr) : -1;
            check("cmp_stall", proc_stall, req && hw < 0);
            if (hw >= 0) check("cmp_rdata", proc_rdata, mc[proc_addr[3:2]][hw].data[32*proc_addr[1:0] +: 32]);
            em_rd = (mst == 2) && !mem_ready;
            em_wr = (mst == 1) && !mem_ready;
            check("cmp_mem_read", mem_read, em_rd);
            check("cmp_mem_write", mem_write, em_wr);
            if (em_rd) check("cmp_mem_addr", mem_addr, proc_addr[29:2]);
            if (em_wr) begin
                check("cmp_mem_addr", mem_addr, mwba);
                check("cmp_mem_wdata", mem_wdata, mwbd);
            end
        end
    end

    bit          seen_rd, seen_wr, wr_before_rd;
    logic [27:0] first_rd, first_wr;

    task automatic req(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int stalls);
        @(posedge clk); #2;
        proc_read = ~wr; proc_write = wr; proc_addr = a; proc_wdata = wd;
        stalls = 0; seen_rd = 0; seen_wr = 0; wr_before_rd = 0; first_rd = '0; first_wr = '0;
        forever begin
            @(negedge clk);
            if (mem_write && !seen_wr) begin
                seen_wr = 1; first_wr = mem_addr;
                if (!seen_rd) wr_before_rd = 1;
            end
            if (mem_read && !seen_rd) begin seen_rd = 1; first_rd = mem_addr; end
            if (!proc_stall) break;
            stalls++;
            if (stalls > 100) begin check("req_timeout", 32'(stalls), 0); break; end
        end
        rd = proc_rdata;
        $display("req %s addr=%h wdata=%h rdata=%h stalls=%0d", wr ? "ST" : "LD", a, wd, rd, stalls);
    endtask

    task automatic idle(input int n);
        @(posedge clk); #2;
        proc_read = 0; proc_write = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int st, k;
        proc_reset = 1; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
        repeat (2) @(posedge clk);
        #2 proc_reset = 0; armed = 1;
        @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", proc_rdata, 0);
        check("rst_stall", proc_stall, 0);

        // First load: one idle cycle plus three refill cycles.
        req(0, 30'h10, 0, rd, st);
        check("B_stalls", 32'(st), 4);
        check("B_rd_addr", first_rd, 28'h4);
        check("B_rdata", rd, 32'h1111_1111);

        req(1, 30'h12, 32'hDEAD_BEEF, rd, st);
        check("C_store_stalls", 32'(st), 0);
        check("C_store_traffic", {seen_rd, seen_wr}, 0);
        req(0, 30'h12, 0, rd, st);
        check("C_load", rd, 32'hDEAD_BEEF);

        req(0, 30'h00, 0, rd, st);
        check("D_stalls", 32'(st), 4);
        req(1, 30'h01, 32'hCAFE_0001, rd, st);
        req(0, 30'h10, 0, rd, st);
        check("D_touch", rd, 32'h1111_1111);

        // Dirty victim, empty buffer: refill first, no write ahead of it.
        req(0, 30'h20, 0, rd, st);
        check("E_stalls", 32'(st), 4);
        check("E_wr_before_rd", wr_before_rd, 0);
        check("E_rd_addr", first_rd, 28'h8);
        check("E_rdata", rd, 32'h0008_0000);

        idle(0);
        k = 0;
        while (!mem_write && k < 50) begin @(negedge clk); k++; end
        check("F_wr_seen", mem_write, 1);
        check("F_wr_addr", mem_addr, 28'h0);
        check("F_wr_word1", mem_wdata[63:32], 32'hCAFE_0001);
        idle(6);

        // Second dirty eviction behind a full buffer.
        req(1, 30'h21, 32'hB00B_0021, rd, st);
        req(0, 30'h30, 0, rd, st);
        check("G1_stalls", 32'(st), 4);
        req(0, 30'h40, 0, rd, st);
        check("G_first_wr", first_wr, 28'h4);
        check("G_wr_before_rd", wr_before_rd, 1);
        check("G_rd_addr", first_rd, 28'h10);
        check("G_rdata", rd, 32'h0010_0000);

        // Reload the block still in the buffer.
        req(0, 30'h21, 0, rd, st);
        check("H_first_wr", first_wr, 28'h8);
        check("H_wr_before_rd", wr_before_rd, 1);
        check("H_rdata", rd, 32'hB00B_0021);
        idle(8);
        k = 0;
        check("H_mem_blk4", bm_get(28'h4), {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111});
        check("H_mem_blk0", bm_get(28'h0), {32'h0000_0003, 32'h0000_0002, 32'hCAFE_0001, 32'h0000_0000});

        // Hits served during a slow background drain.
        lat = 5;
        req(1, 30'h41, 32'h5555_0041, rd, st);
        req(1, 30'h22, 32'h6666_0022, rd, st);
        req(0, 30'h50, 0, rd, st);
        check("I_miss_stalls", 32'(st), 6);
        req(0, 30'h22, 0, rd, st);
        check("I_hit_stalls", 32'(st), 0);
        check("I_hit_rdata", rd, 32'h6666_0022);
        check("I_hit_draining", seen_wr, 1);
        check("I_drain_addr", first_wr, 28'h10);
        req(1, 30'h53, 32'h7777_0053, rd, st);
        check("I_store_stalls", 32'(st), 0);
        check("I_store_draining", seen_wr, 1);
        idle(0);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (!mem_write) break;
            k++;
        end
        check("I_drain_tail", 32'(k), 2);
        idle(4);
        req(0, 30'h60, 0, rd, st);
        check("I2_stalls", 32'(st), 6);
        req(0, 30'h70, 0, rd, st);
        check("I3_first_wr", first_wr, 28'h8);
        check("I3_wr_before_rd", wr_before_rd, 1);
        idle(20);
        check("I_mem_blk14_w3", bm_get(28'h14) >> 96, 32'h7777_0053);
        check("I_mem_blk8_w2", (bm_get(28'h8) >> 64) & 128'hFFFF_FFFF, 32'h6666_0022);
        check("I_mem_blk10_w1", (bm_get(28'h10) >> 32) & 128'hFFFF_FFFF, 32'h5555_0041);
        lat = 3;

        // Reset lands in the cycle mem_ready returns: the refill must be abandoned.
        @(posedge clk); #2;
        proc_read = 1; proc_addr = 30'h04;
        repeat (3) @(posedge clk);
        #2 proc_reset = 1; proc_read = 0;
        @(posedge clk); #2 proc_reset = 0;
        @(negedge clk);
        check("J_mem_read", mem_read, 0);
        check("J_mem_write", mem_write, 0);
        check("J_stall", proc_stall, 0);
        req(0, 30'h04, 0, rd, st);
        check("J_stalls", 32'(st), 4);
        check("J_rdata", rd, 32'h0001_0000);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
